imem_port_ctrl: RTL and testbench

Single-port instruction-memory controller that shares the instruction memory between the IF-stage fetch path and a secondary loader/debug requester. It issues one memory access at a time against a fixed-latency memory and returns read data to the requester that was granted. It also produces the `stall_PC` hold signal consumed by the IF stage whenever the current fetch has not yet been served. The block sits between the IF stage (IREQ/IADDR) and the instruction memory macro.

---
 rtl/imem_if.sv | 35 +++
 rtl/imem_port_ctrl.sv | 125 ++++++++++++
 tb/tb_imem_port_ctrl.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_if.sv
// Instruction-memory port bundle: IF fetch path, loader/debug requester and
// the single-port memory macro. The controller uses the slave view; the
// requesters and memory model use the master view.
interface imem_if;
   logic        f_req;
   logic [29:0] f_addr;
   logic        flush;
   logic        f_rvalid;
   logic [31:0] f_rdata;
   logic        stall_PC;
   logic        l_req;
   logic        l_we;
   logic [29:0] l_addr;
   logic [31:0] l_wdata;
   logic        l_gnt;
   logic        l_rvalid;
   logic [31:0] l_rdata;
   logic        m_req;
   logic        m_we;
   logic [29:0] m_addr;
   logic [31:0] m_wdata;
   logic [31:0] m_rdata;

   modport slave (
      input  f_req, f_addr, flush, l_req, l_we, l_addr, l_wdata, m_rdata,
      output f_rvalid, f_rdata, stall_PC, l_gnt, l_rvalid, l_rdata,
             m_req, m_we, m_addr, m_wdata
   );

   modport master (
      output f_req, f_addr, flush, l_req, l_we, l_addr, l_wdata, m_rdata,
      input  f_rvalid, f_rdata, stall_PC, l_gnt, l_rvalid, l_rdata,
             m_req, m_we, m_addr, m_wdata
   );
endinterface

// File: rtl/imem_port_ctrl.sv
// Single-port instruction-memory controller shared by the IF fetch path and a
// loader/debug requester. One access outstanding at a time against a
// fixed-latency memory; a new access may issue in the completion cycle.
//
// Build option: IMEM_LOADER_FAIRNESS_EN -- when defined, the loader may win at
// most LOADER_MAX contested arbitrations in a row before the fetch gets a turn.
// When undefined the loader has strict priority.
//
// state  | meaning
// IDLE   | no access outstanding
// F_WAIT | fetch outstanding, waiting MEM_LAT cycles for read data
// L_WAIT | loader read or write outstanding
module imem_port_ctrl #(
   parameter int MEM_LAT    = 1,
   parameter int LOADER_MAX = 4
) (
   input logic   CLK,
   input logic   RSTN,
   imem_if.slave bus
);

   if (MEM_LAT < 1 || MEM_LAT > 7) begin : g_bad_lat
      $error("imem_port_ctrl: MEM_LAT must be 1..7");
   end
   if (LOADER_MAX < 1 || LOADER_MAX > 15) begin : g_bad_lmax
      $error("imem_port_ctrl: LOADER_MAX must be 1..15");
   end

   localparam logic [2:0] LAT_INIT = 3'(MEM_LAT);

   typedef enum logic [1:0] {IDLE, F_WAIT, L_WAIT} state_t;

   state_t      state_q, state_d;
   logic [2:0]  lat_q, lat_d;
   logic        kill_q, kill_d;
   logic        we_q, we_d;
`ifdef IMEM_LOADER_FAIRNESS_EN
   logic [3:0]  fair_q, fair_d;
`endif

   logic done, can_issue, fetch_turn, issue_f, issue_l, f_done, l_done;

   // Arbitration and completion decode; everything is gated by RSTN so the
   // outputs drop asynchronously with reset.
   always_comb begin
      done      = (state_q != IDLE) && (lat_q == 3'd1);
      can_issue = RSTN && ((state_q == IDLE) || done);
`ifdef IMEM_LOADER_FAIRNESS_EN
      fetch_turn = bus.f_req && (fair_q >= 4'(LOADER_MAX));
`else
      fetch_turn = 1'b0;
`endif
      issue_l = can_issue && bus.l_req && !fetch_turn;
      issue_f = can_issue && bus.f_req && !issue_l;
      // A flush arriving in the completion cycle still kills the fetch.
      f_done  = RSTN && done && (state_q == F_WAIT) && !kill_q && !bus.flush;
      l_done  = RSTN && done && (state_q == L_WAIT) && !we_q;
   end

   assign bus.m_req    = issue_f | issue_l;
   assign bus.m_we     = issue_l & bus.l_we;
   assign bus.m_addr   = issue_l ? bus.l_addr : (issue_f ? bus.f_addr : 30'd0);
   assign bus.m_wdata  = (issue_l && bus.l_we) ? bus.l_wdata : 32'd0;
   assign bus.l_gnt    = issue_l;
   assign bus.f_rvalid = f_done;
   assign bus.f_rdata  = f_done ? bus.m_rdata : 32'd0;
   assign bus.l_rvalid = l_done;
   assign bus.l_rdata  = l_done ? bus.m_rdata : 32'd0;
   assign bus.stall_PC = RSTN & bus.f_req & ~f_done;

   // Next-state: issue takes priority over plain completion; otherwise count
   // the latency down and collect flushes against the outstanding fetch.
   always_comb begin
      state_d = state_q;
      lat_d   = lat_q;
      kill_d  = kill_q;
      we_d    = we_q;
      if (issue_f) begin
         state_d = F_WAIT;
         lat_d   = LAT_INIT;
         kill_d  = bus.flush;
         we_d    = 1'b0;
      end else if (issue_l) begin
         state_d = L_WAIT;
         lat_d   = LAT_INIT;
         kill_d  = 1'b0;
         we_d    = bus.l_we;
      end else if (done) begin
         state_d = IDLE;
         lat_d   = 3'd0;
         kill_d  = 1'b0;
         we_d    = 1'b0;
      end else if (state_q != IDLE) begin
         lat_d = lat_q - 3'd1;
         if ((state_q == F_WAIT) && bus.flush) kill_d = 1'b1;
      end
`ifdef IMEM_LOADER_FAIRNESS_EN
      fair_d = fair_q;
      if (issue_f) fair_d = 4'd0;
      else if (issue_l && bus.f_req && (fair_q != 4'hF)) fair_d = fair_q + 4'd1;
`endif
   end

   // Controller state registers.
   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         state_q <= IDLE;
         lat_q   <= 3'd0;
         kill_q  <= 1'b0;
         we_q    <= 1'b0;
`ifdef IMEM_LOADER_FAIRNESS_EN
         fair_q  <= 4'd0;
`endif
      end else begin
         state_q <= state_d;
         lat_q   <= lat_d;
         kill_q  <= kill_d;
         we_q    <= we_d;
`ifdef IMEM_LOADER_FAIRNESS_EN
         fair_q  <= fair_d;
`endif
      end
   end

endmodule

// File: tb/tb_imem_port_ctrl.sv
// Bench for imem_port_ctrl: three instances with MEM_LAT = 1, 2, 3 share the
// stimulus; only the instance selected by sel sees requests. Expected issues
// and read responses are queued at stimulus time and popped by a monitor.
module tb_imem_port_ctrl;

   localparam int LMAX = 4;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   int          sel = 0;
   logic        f_req = 1'b0, flush = 1'b0, l_req = 1'b0, l_we = 1'b0;
   logic [29:0] f_addr = '0, l_addr = '0;
   logic [31:0] l_wdata = '0;

   logic [2:0]  m_req_a, m_we_a, l_gnt_a, f_rvalid_a, l_rvalid_a, stall_a;
   logic [29:0] m_addr_a [3];
   logic [31:0] m_wdata_a [3];
   logic [31:0] f_rdata_a [3];
   logic [31:0] l_rdata_a [3];

   int checks = 0;
   int passes = 0;

   typedef struct {
      int          dut;
      logic        is_l;
      logic        we;
      logic [29:0] addr;
      logic [31:0] wdata;
   } iss_t;

   typedef struct {
      int          dut;
      logic        is_l;
      logic [31:0] data;
   } rsp_t;

   iss_t iss_q[$];
   rsp_t rsp_q[$];

   always #5 clk = ~clk;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      imem_if      bus();
      logic [31:0] mem  [0:255];
      logic [31:0] pipe [0:7];

      initial begin
         for (int i = 0; i < 256; i++) mem[i] = 32'hC0DE_0000 | 32'(i);
         for (int i = 0; i < 8; i++) pipe[i] = 32'd0;
      end

      assign bus.f_req   = f_req && (sel == g);
      assign bus.l_req   = l_req && (sel == g);
      assign bus.f_addr  = f_addr;
      assign bus.flush   = flush;
      assign bus.l_we    = l_we;
      assign bus.l_addr  = l_addr;
      assign bus.l_wdata = l_wdata;
      assign bus.m_rdata = pipe[g];

      always @(posedge clk) begin
         if (bus.m_req && bus.m_we) mem[bus.m_addr[7:0]] <= bus.m_wdata;
         pipe[0] <= mem[bus.m_addr[7:0]];
         for (int k = 1; k < 8; k++) pipe[k] <= pipe[k-1];
      end

      imem_port_ctrl #(.MEM_LAT(g + 1), .LOADER_MAX(LMAX)) u_dut (
         .CLK (clk),
         .RSTN(rstn),
         .bus (bus)
      );

      assign m_req_a[g]    = bus.m_req;
      assign m_we_a[g]     = bus.m_we;
      assign l_gnt_a[g]    = bus.l_gnt;
      assign f_rvalid_a[g] = bus.f_rvalid;
      assign l_rvalid_a[g] = bus.l_rvalid;
      assign stall_a[g]    = bus.stall_PC;
      assign m_addr_a[g]   = bus.m_addr;
      assign m_wdata_a[g]  = bus.m_wdata;
      assign f_rdata_a[g]  = bus.f_rdata;
      assign l_rdata_a[g]  = bus.l_rdata;
   end

   function automatic logic [31:0] memv(logic [29:0] a);
      return 32'hC0DE_0000 | {24'd0, a[7:0]};
   endfunction

   task automatic check_w(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %h want %h", name, act, exp);
   endtask

   task automatic check_b(string name, logic act, logic exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %b want %b", name, act, exp);
   endtask

   task automatic unexpected(string name, int g);
      checks++;
      $display("FAIL %s: got event on dut %0d want none queued", name, g);
   endtask

   task automatic push_f(int dut, logic [29:0] a, bit with_rsp);
      iss_q.push_back('{dut, 1'b0, 1'b0, a, 32'd0});
      if (with_rsp) rsp_q.push_back('{dut, 1'b0, memv(a)});
   endtask

   task automatic push_l(int dut, logic we, logic [29:0] a, logic [31:0] wd,
                         bit with_rsp, logic [31:0] rd);
      iss_q.push_back('{dut, 1'b1, we, a, wd});
      if (with_rsp) rsp_q.push_back('{dut, 1'b1, rd});
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   // Monitor: every issue and every read completion must match the head of
   // its queue.
   always @(negedge clk) begin : mon
      iss_t ei;
      rsp_t er;
      for (int g = 0; g < 3; g++) begin
         if (m_req_a[g]) begin
            if (iss_q.size() == 0) unexpected("issue", g);
            else begin
               ei = iss_q.pop_front();
               check_w("iss_dut", 32'(g), 32'(ei.dut));
               check_b("iss_owner", l_gnt_a[g], ei.is_l);
               check_b("iss_we", m_we_a[g], ei.we);
               check_w("iss_addr", {2'b0, m_addr_a[g]}, {2'b0, ei.addr});
               if (ei.we) check_w("iss_wdata", m_wdata_a[g], ei.wdata);
            end
         end
         if (f_rvalid_a[g] || l_rvalid_a[g]) begin
            if (rsp_q.size() == 0) unexpected("rvalid", g);
            else begin
               er = rsp_q.pop_front();
               check_w("rsp_dut", 32'(g), 32'(er.dut));
               check_b("rsp_is_loader", l_rvalid_a[g], er.is_l);
               check_w("rsp_data", er.is_l ? l_rdata_a[g] : f_rdata_a[g], er.data);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      int  cnt;
      bit  prev_f, grant_f;

      // Reset: outputs held at 0 even with a live fetch request.
      sel = 0;
      f_req = 1'b1;
      @(negedge clk);
      check_b("rst_m_req", m_req_a[0], 1'b0);
      check_b("rst_stall", stall_a[0], 1'b0);
      check_b("rst_f_rvalid", f_rvalid_a[0], 1'b0);
      check_b("rst_l_gnt", l_gnt_a[0], 1'b0);
      f_req = 1'b0;
      @(negedge clk);
      rstn = 1'b1;
      next_cycle();

      // MEM_LAT=1 back-to-back fetch.
      sel = 0;
      f_req = 1'b1; f_addr = 30'h0; push_f(0, 30'h0, 1);
      @(negedge clk); check_b("t1_stall_c0", stall_a[0], 1'b1);
      next_cycle();
      f_addr = 30'h1; push_f(0, 30'h1, 1);
      @(negedge clk); check_b("t1_stall_c1", stall_a[0], 1'b0);
      next_cycle();
      f_addr = 30'h2; push_f(0, 30'h2, 1);
      @(negedge clk); check_b("t1_stall_c2", stall_a[0], 1'b0);
      next_cycle();
      f_req = 1'b0;
      next_cycle();

      // MEM_LAT=3 single fetch, then a back-to-back refetch whose request
      // drops while outstanding (data still returned).
      sel = 2;
      f_req = 1'b1; f_addr = 30'h10; push_f(2, 30'h10, 1);
      @(negedge clk); check_b("t2_stall_c0", stall_a[2], 1'b1);
      next_cycle();
      @(negedge clk); check_b("t2_stall_c1", stall_a[2], 1'b1);
      next_cycle();
      @(negedge clk); check_b("t2_stall_c2", stall_a[2], 1'b1);
      next_cycle();
      push_f(2, 30'h10, 1);
      @(negedge clk); check_b("t2_stall_c3", stall_a[2], 1'b0);
      next_cycle();
      f_req = 1'b0;
      repeat (3) next_cycle();

      // MEM_LAT=2 fetch killed by flush; redirected fetch issues on completion.
      sel = 1;
      f_req = 1'b1; f_addr = 30'h20; push_f(1, 30'h20, 0);
      next_cycle();
      flush = 1'b1; f_addr = 30'h40;
      next_cycle();
      flush = 1'b0; push_f(1, 30'h40, 1);
      @(negedge clk);
      check_b("t3_killed", f_rvalid_a[1], 1'b0);
      check_b("t3_stall", stall_a[1], 1'b1);
      next_cycle();
      f_req = 1'b0;
      repeat (2) next_cycle();

      // Loader write then read back, MEM_LAT=2.
      l_req = 1'b1; l_we = 1'b1; l_addr = 30'h5; l_wdata = 32'hDEADBEEF;
      push_l(1, 1'b1, 30'h5, 32'hDEADBEEF, 0, 32'd0);
      @(negedge clk); check_b("t4_gnt_wr", l_gnt_a[1], 1'b1);
      next_cycle();
      l_we = 1'b0; l_wdata = 32'd0;
      @(negedge clk); check_b("t4_gnt_busy", l_gnt_a[1], 1'b0);
      next_cycle();
      push_l(1, 1'b0, 30'h5, 32'd0, 1, 32'hDEADBEEF);
      @(negedge clk);
      check_b("t4_gnt_rd", l_gnt_a[1], 1'b1);
      check_b("t4_no_wr_rvalid", l_rvalid_a[1], 1'b0);
      next_cycle();
      l_req = 1'b0;
      repeat (2) next_cycle();

      // Contested arbitration, MEM_LAT=1.
      sel = 0;
      f_req = 1'b1; f_addr = 30'h3;
      l_req = 1'b1; l_we = 1'b0; l_addr = 30'h7;
      cnt = 0; prev_f = 1'b0;
      for (int i = 0; i < 10; i++) begin
`ifdef IMEM_LOADER_FAIRNESS_EN
         if (cnt >= LMAX) begin grant_f = 1'b1; cnt = 0; end
         else begin grant_f = 1'b0; cnt++; end
`else
         grant_f = 1'b0;
`endif
         if (grant_f) push_f(0, 30'h3, 1);
         else push_l(0, 1'b0, 30'h7, 32'd0, 1, memv(30'h7));
         @(negedge clk); check_b("t5_stall", stall_a[0], !prev_f);
         prev_f = grant_f;
         next_cycle();
      end
      f_req = 1'b0; l_req = 1'b0;
      repeat (2) next_cycle();

      // Reset during a loader read on MEM_LAT=3.
      sel = 2;
      l_req = 1'b1; l_we = 1'b0; l_addr = 30'h9;
      push_l(2, 1'b0, 30'h9, 32'd0, 0, 32'd0);
      next_cycle();
      l_req = 1'b0; f_req = 1'b1; f_addr = 30'h0;
      #2 rstn = 1'b0;
      #1;
      check_b("t6_rst_m_req", m_req_a[2], 1'b0);
      check_b("t6_rst_stall", stall_a[2], 1'b0);
      check_b("t6_rst_l_rvalid", l_rvalid_a[2], 1'b0);
      check_b("t6_rst_l_gnt", l_gnt_a[2], 1'b0);
      check_b("t6_rst_f_rvalid", f_rvalid_a[2], 1'b0);
      repeat (2) next_cycle();
      push_f(2, 30'h0, 1);
      #2 rstn = 1'b1;
      next_cycle();
      f_req = 1'b0;
      repeat (5) next_cycle();

      check_w("iss_q_empty", 32'(iss_q.size()), 32'd0);
      check_w("rsp_q_empty", 32'(rsp_q.size()), 32'd0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
